// File: rtl/param_counter_pkg.sv
// Shared mode encodings and range-bound helpers
// for the parametrised parity counter.
package param_counter_pkg;

    localparam logic [1:0] MODE_ALL  = 2'b00;
    localparam logic [1:0] MODE_EVEN = 2'b01;
    localparam logic [1:0] MODE_ODD  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    function automatic int lo_bound(input logic [1:0] mode);
        return (mode == MODE_ODD) ? 1 : 0;
    endfunction

    function automatic int hi_bound(
        input logic [1:0] mode,
        input int         max_val
    );
        int res;
        res = max_val;
        case (mode)
            MODE_EVEN: res = max_val & ~1;
            MODE_ODD:  res = max_val[0] ? max_val : max_val - 1;
            default:   res = max_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/parity_align.sv
// Snaps a value onto the parity grid of the active mode,
// clamping odd values to the upper bound.
module parity_align
    import param_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] value,
    input  logic [1:0]     mode,
    input  logic [WIDTH:0] hi,
    output logic [WIDTH:0] aligned
);

    always_comb begin
        aligned = value;
        case (mode)
            MODE_EVEN: aligned = {value[WIDTH:1], 1'b0};
            MODE_ODD: begin
                aligned = {value[WIDTH:1], 1'b1};
                if (aligned > hi) aligned = hi;
            end
            default: aligned = value;
        endcase
    end

endmodule

// File: rtl/param_parity_counter.sv
// Loadable up/down counter over [0, MAX_VAL] with all/even/odd/hold
// modes, terminal-count pulse and load range error pulse.
module param_parity_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             load_err
);

    localparam int W1 = WIDTH + 1;

    logic [WIDTH:0]   lo_ext;
    logic [WIDTH:0]   hi_ext;
    logic [WIDTH:0]   data_ext;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_al;
    logic [WIDTH:0]   cnt_al;
    logic [WIDTH:0]   step;
    logic [WIDTH-1:0] next_count;
    logic             next_tc;
    logic             next_err;

    assign lo_ext   = W1'(lo_bound(mode));
    assign hi_ext   = W1'(hi_bound(mode, MAX_VAL));
    assign data_ext = {1'b0, data_in};
    assign cnt_ext  = {1'b0, count};
    assign step     = (mode == MODE_ALL) ? W1'(1) : W1'(2);

    parity_align #(.WIDTH(WIDTH)) u_load_align (
        .value   (data_ext),
        .mode    (mode),
        .hi      (hi_ext),
        .aligned (load_al)
    );

    // Re-aligning the live count lets mode changes apply without a bubble.
    parity_align #(.WIDTH(WIDTH)) u_cnt_align (
        .value   (cnt_ext),
        .mode    (mode),
        .hi      (hi_ext),
        .aligned (cnt_al)
    );

    always_comb begin
        next_count = count;
        next_tc    = 1'b0;
        next_err   = 1'b0;
        if (load) begin
            if (data_ext > W1'(MAX_VAL)) begin
                next_count = WIDTH'(lo_ext);
                next_err   = 1'b1;
            end else begin
                next_count = WIDTH'(load_al);
            end
        end else if (mode != MODE_HOLD && en) begin
            if (up) begin
                if (cnt_al >= hi_ext) begin
                    next_count = WIDTH'(lo_ext);
                    next_tc    = 1'b1;
                end else begin
                    next_count = WIDTH'(cnt_al + step);
                end
            end else begin
                if (cnt_al <= lo_ext) begin
                    next_count = WIDTH'(hi_ext);
                    next_tc    = 1'b1;
                end else begin
                    next_count = WIDTH'(cnt_al - step);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= next_count;
            tc       <= next_tc;
            load_err <= next_err;
        end
    end

endmodule

// File: tb/tb_param_parity_counter.sv
// Randomised and directed bench for param_parity_counter
// against an arithmetic reference model (WIDTH=4, MAX_VAL=9).
module tb_param_parity_counter;

    localparam int WIDTH = 4;
    localparam int MAXV  = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic             up = 1'b1;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             load_err;

    int n_cmp = 0;
    int n_bad = 0;
    int m_count = 0;
    int m_tc = 0;
    int m_err = 0;

    param_parity_counter #(.WIDTH(WIDTH), .MAX_VAL(MAXV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .up       (up),
        .mode     (mode),
        .data_in  (data_in),
        .count    (count),
        .tc       (tc),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int mlo(input int md);
        return (md == 2) ? 1 : 0;
    endfunction

    function automatic int mhi(input int md);
        if (md == 1) return MAXV - (MAXV % 2);
        if (md == 2) return (MAXV % 2 == 1) ? MAXV : MAXV - 1;
        return MAXV;
    endfunction

    function automatic int malign(input int x, input int md);
        int y;
        y = x;
        if (md == 1) y = x - (x % 2);
        if (md == 2) begin
            y = (x % 2 == 1) ? x : x + 1;
            if (y > mhi(md)) y = mhi(md);
        end
        return y;
    endfunction

    task automatic model_edge();
        int md;
        int a;
        int stp;
        md = int'(mode);
        if (load) begin
            m_tc = 0;
            if (int'(data_in) > MAXV) begin
                m_count = mlo(md);
                m_err = 1;
            end else begin
                m_count = malign(int'(data_in), md);
                m_err = 0;
            end
        end else if (md == 3 || !en) begin
            m_tc = 0;
            m_err = 0;
        end else begin
            a = malign(m_count, md);
            stp = (md == 0) ? 1 : 2;
            m_err = 0;
            m_tc = 0;
            if (up) begin
                if (a >= mhi(md)) begin
                    m_count = mlo(md);
                    m_tc = 1;
                end else m_count = a + stp;
            end else begin
                if (a <= mlo(md)) begin
                    m_count = mhi(md);
                    m_tc = 1;
                end else m_count = a - stp;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".count"}, int'(count), m_count);
        chk({tag, ".tc"}, int'(tc), m_tc);
        chk({tag, ".err"}, int'(load_err), m_err);
    endtask

    task automatic drive(input logic l, input logic e, input logic u,
                         input logic [1:0] md, input int d);
        load = l;
        en = e;
        up = u;
        mode = md;
        data_in = WIDTH'(d);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        m_count = 0;
        m_tc = 0;
        m_err = 0;
        #1;
        chk({tag, ".rst_count"}, int'(count), 0);
        chk({tag, ".rst_tc"}, int'(tc), 0);
        chk({tag, ".rst_err"}, int'(load_err), 0);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #3;
        chk("reset.count", int'(count), 0);
        chk("reset.tc", int'(tc), 0);
        chk("reset.err", int'(load_err), 0);
        @(negedge clk);
        rst = 1'b1;

        // even mode: 2,4,6,8,0
        drive(1, 0, 1, 2'b01, 3);
        step("even_load");
        chk("even_load.abs", int'(count), 2);
        drive(0, 1, 1, 2'b01, 0);
        repeat (4) step("even_up");
        chk("even_wrap.abs", int'(count), 0);
        chk("even_wrap.tc_abs", int'(tc), 1);

        // odd mode: 3,5,7,9,1 then down 9,7
        drive(1, 0, 1, 2'b10, 3);
        step("odd_load");
        drive(0, 1, 1, 2'b10, 0);
        repeat (4) step("odd_up");
        chk("odd_wrap.abs", int'(count), 1);
        drive(0, 1, 0, 2'b10, 0);
        step("odd_down_wrap");
        chk("odd_down_wrap.abs", int'(count), 9);
        chk("odd_down_wrap.tc_abs", int'(tc), 1);
        step("odd_down");

        // all mode 8 -> 9,0,1 then hold
        drive(1, 0, 1, 2'b00, 8);
        step("all_load");
        drive(0, 1, 1, 2'b00, 0);
        repeat (3) step("all_up");
        drive(0, 1, 1, 2'b11, 0);
        repeat (3) step("hold");
        chk("hold.abs", int'(count), 1);

        // even 4 switched to odd up: 7,9,1
        drive(1, 0, 1, 2'b01, 4);
        step("sw_load");
        drive(0, 1, 1, 2'b10, 0);
        step("sw_first");
        chk("sw_first.abs", int'(count), 7);
        repeat (2) step("sw_up");

        // out-of-range load, then load beats en
        drive(1, 0, 1, 2'b10, 12);
        step("bad_load");
        chk("bad_load.err_abs", int'(load_err), 1);
        drive(1, 1, 1, 2'b00, 5);
        step("load_wins");
        chk("load_wins.abs", int'(count), 5);

        // async reset mid-count
        drive(0, 1, 1, 2'b00, 0);
        step("pre_rst");
        async_reset("mid");
        step("post_rst");
        chk("post_rst.abs", int'(count), 1);

        // randomised traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 8) == 0, ($urandom % 4) != 0,
                  1'($urandom), 2'($urandom), int'($urandom % 16));
            step("rand");
            if (($urandom % 97) == 0) async_reset("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_parity_counter.md
Name: param_parity_counter

Overview:
- Parametrised successor to the team's 4-bit even/odd loadable counter.
- Counts over a configurable range [0, MAX_VAL] in four modes: all values, even only, odd only, hold.
- Adds up/down direction, count enable, modulo wrap with a terminal-count pulse, and load range checking.
- Serves as a sequence/address generator in datapath test structures.

Parameters:
- WIDTH, 4, counter and data_in width in bits (WIDTH >= 2).
- MAX_VAL, 2**WIDTH-1, inclusive upper bound of the count range (1 <= MAX_VAL <= 2**WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- load  input  1  synchronous parallel load; has priority over en.
- up  input  1  direction: 1 = up, 0 = down.
- mode  input  2  00 all (step 1), 01 even (step 2), 10 odd (step 2), 11 hold.
- data_in  input  WIDTH  load value.
- count  output  WIDTH  registered count.
- tc  output  1  registered terminal-count pulse.
- load_err  output  1  registered pulse: the load value was out of range.

Behaviour:
- Reset: rst low asynchronously forces count=0, tc=0, load_err=0. Outputs stay there while rst is low. Counting resumes on the first rising edge after rst goes high.
- Range per mode:
  - lo: 0 for all/even, 1 for odd.
  - hi: MAX_VAL for all. MAX_VAL with LSB cleared for even. For odd: MAX_VAL if MAX_VAL is odd, else MAX_VAL-1.
- align(x):
  - all: x.
  - even: x with LSB cleared.
  - odd: x with LSB set; if the result exceeds hi, use hi.
- Priority each rising edge: load > hold mode > en > idle.
- Load:
  - If data_in > MAX_VAL: count <= lo and load_err=1.
  - Otherwise: count <= align(data_in) and load_err=0.
  - tc=0. Load is honoured even when mode=11.
- Hold (mode=11, no load): count holds; tc=0, load_err=0.
- Count (en=1, no load, mode != 11): let a = align(count); step = 1 (all) or 2 (even/odd).
  - up: if a >= hi then count <= lo and tc=1; else count <= a+step and tc=0.
  - down: if a <= lo then count <= hi and tc=1; else count <= a-step and tc=0.
- Idle (en=0, no load): count holds; tc=0, load_err=0.
- tc and load_err are single-cycle pulses, asserted in the same cycle as the count value that caused them. Back-to-back wraps give back-to-back pulses.
- Mode or direction change mid-count takes effect on the next enabled edge via align() (even count 4 switched to odd up gives 7). No extra cycle, no error.
- Arithmetic uses WIDTH+1 bits internally. count never leaves [lo, hi] after any load or step.
- Zero latency beyond the register: the response to inputs sampled at edge N is visible after edge N.

Decomposition:
- Shared package param_counter_pkg:
  - mode encodings MODE_ALL=2'b00, MODE_EVEN=2'b01, MODE_ODD=2'b10, MODE_HOLD=2'b11.
  - functions for lo/hi bound computation.
- One combinational sub-module, parity_align: inputs value, mode, hi; output the aligned value. Instantiated twice, once for the load path and once for the count path.
- The top module holds the registers and the priority logic.

Test Plan (WIDTH=4, MAX_VAL=9):
- Reset then load=1, data_in=3, mode=01, then en=1, up=1 for 4 cycles -> count 2,4,6,8,0; tc=1 only on the cycle count=0.
- mode=10, load data_in=3, en=1, up=1 -> count 3,5,7,9,1; tc pulses at 1. Then up=0 from 1 -> count 9, tc=1, then 7.
- mode=00, load 8, up=1 -> 9,0 (tc),1. Then mode=11 with en=1 for 3 cycles -> count holds at 1, tc=0.
- mode=01 at count 4, switch to mode=10 with en=1, up=1 -> count 7 on the next edge, then 9, then 1 (tc).
- load data_in=12 in mode=10 -> count=1, load_err=1 for one cycle. load and en both high -> the load value wins.
- Assert rst low between clock edges mid-count -> count=0, tc=0 immediately. Release rst -> counting restarts from 0 on the next edge.
